// File: rtl/mem_arbiter.sv
// Shares the single PMEM port between instruction fetch (IFU) and load/store (LSU).
// One transaction is outstanding at a time. LSU wins ties until IFU has been
// passed over STARVE_LIMIT times. A lost response becomes an error after TIMEOUT cycles.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] ERR_DATA     = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IFU,
    WAIT_LSU
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            prefer_ifu;
  logic            grant_ifu;
  logic            grant_lsu;
  logic            resp_hit;
  logic            tmo_hit;
  logic [31:0]     resp_data;

  // State, starvation and timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  // Arbitration, response routing and next-state logic
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    prefer_ifu = (starve_q == SW'(STARVE_LIMIT));
    grant_ifu  = 1'b0;
    grant_lsu  = 1'b0;
    resp_hit   = 1'b0;
    tmo_hit    = 1'b0;
    resp_data  = '0;
    ifu_ready  = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_err    = 1'b0;
    lsu_ready  = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_err    = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        grant_ifu = ifu_valid && (!lsu_valid || prefer_ifu);
        grant_lsu = !grant_ifu && lsu_valid;
        mem_valid = grant_ifu || grant_lsu;
        if (grant_ifu) begin
          mem_addr  = ifu_addr;
          ifu_ready = mem_ready;
        end else if (grant_lsu) begin
          mem_addr  = lsu_addr;
          mem_wen   = lsu_wen;
          mem_wdata = lsu_wdata;
          mem_wmask = lsu_wmask;
          lsu_ready = mem_ready;
        end
        if (!ifu_valid || (grant_ifu && mem_ready)) begin
          starve_d = '0;
        end else if (grant_lsu && mem_ready && !prefer_ifu) begin
          starve_d = starve_q + SW'(1);
        end
        if (mem_valid && mem_ready) begin
          state_d = grant_ifu ? WAIT_IFU : WAIT_LSU;
          tmo_d   = '0;
        end
      end
      WAIT_IFU, WAIT_LSU: begin
        tmo_d     = tmo_q + TW'(1);
        resp_hit  = mem_rvalid;
        tmo_hit   = !mem_rvalid && (tmo_q == TW'(TIMEOUT - 1));
        resp_data = resp_hit ? mem_rdata : ERR_DATA;
        if (resp_hit || tmo_hit) begin
          state_d = IDLE;
          if (state_q == WAIT_IFU) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = resp_data;
            ifu_err    = tmo_hit;
          end else begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = resp_data;
            lsu_err    = tmo_hit;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held low for as long as reset is asserted
    if (rst) begin
      ifu_ready  = 1'b0;
      ifu_rvalid = 1'b0;
      ifu_rdata  = '0;
      ifu_err    = 1'b0;
      lsu_ready  = 1'b0;
      lsu_rvalid = 1'b0;
      lsu_rdata  = '0;
      lsu_err    = 1'b0;
      mem_valid  = 1'b0;
      mem_addr   = '0;
      mem_wen    = 1'b0;
      mem_wdata  = '0;
      mem_wmask  = '0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int SL      = 4;
  localparam int TMO     = 8;
  localparam logic [31:0] ERRD = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding flag, owner, acceptance cycle, starvation count
  int  cyc      = 0;
  bit  m_busy   = 0;
  bit  m_lsu    = 0;
  int  m_t0     = 0;
  int  m_starve = 0;
  bit  last_ifu_acc, last_lsu_acc;

  mem_arbiter #(
    .STARVE_LIMIT(SL),
    .TIMEOUT     (TMO),
    .ERR_DATA    (ERRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_valid),
    .ifu_ready (ifu_ready),
    .ifu_addr  (ifu_addr),
    .ifu_rvalid(ifu_rvalid),
    .ifu_rdata (ifu_rdata),
    .ifu_err   (ifu_err),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_wen   (lsu_wen),
    .lsu_wdata (lsu_wdata),
    .lsu_wmask (lsu_wmask),
    .lsu_rvalid(lsu_rvalid),
    .lsu_rdata (lsu_rdata),
    .lsu_err   (lsu_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: predict outputs from the model, compare, clock, update the model
  task automatic step();
    logic        e_mv, e_ir, e_lr, e_iv, e_ie, e_lv, e_le, e_busy, e_wen;
    logic [31:0] e_addr, e_wdata, e_ird, e_lrd, rd;
    logic [7:0]  e_wmask;
    bit          win_ifu, win_lsu, resp, tmo;
    e_mv = 0; e_ir = 0; e_lr = 0; e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0;
    e_busy = 0; e_wen = 0; e_addr = '0; e_wdata = '0; e_ird = '0; e_lrd = '0;
    e_wmask = '0; win_ifu = 0; win_lsu = 0; resp = 0; tmo = 0; rd = '0;
    #1;
    if (!rst) begin
      if (!m_busy) begin
        win_ifu = ifu_valid && (!lsu_valid || m_starve == SL);
        win_lsu = !win_ifu && lsu_valid;
        e_mv = win_ifu || win_lsu;
        e_ir = win_ifu && mem_ready;
        e_lr = win_lsu && mem_ready;
        if (win_ifu) e_addr = ifu_addr;
        if (win_lsu) begin
          e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
        end
      end else begin
        e_busy = 1;
        resp = mem_rvalid;
        tmo  = !resp && (cyc - m_t0 == TMO);
        rd   = resp ? mem_rdata : ERRD;
        if (resp || tmo) begin
          if (m_lsu) begin e_lv = 1; e_le = tmo; e_lrd = rd; end
          else       begin e_iv = 1; e_ie = tmo; e_ird = rd; end
        end
      end
    end
    check("ctl", {56'd0, mem_valid, ifu_ready, lsu_ready, ifu_rvalid, ifu_err, lsu_rvalid, lsu_err, busy},
                 {56'd0, e_mv, e_ir, e_lr, e_iv, e_ie, e_lv, e_le, e_busy});
    if (e_mv) begin
      check("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
      check("mem_wr", {mem_wen, mem_wmask, mem_wdata}, {e_wen, e_wmask, e_wdata});
    end
    check("rdata", {ifu_rdata, lsu_rdata}, {e_ird, e_lrd});
    last_ifu_acc = e_ir;
    last_lsu_acc = e_lr;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (e_ir || e_lr) begin m_busy = 1; m_lsu = e_lr; m_t0 = cyc; end
      if (!ifu_valid || e_ir) m_starve = 0;
      else if (e_lr && m_starve < SL) m_starve++;
    end else if (resp || tmo) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  bit ifu_pend, lsu_pend;

  initial begin
    rst = 1; ifu_valid = 0; ifu_addr = '0; lsu_valid = 0; lsu_addr = '0; lsu_wen = 0;
    lsu_wdata = '0; lsu_wmask = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    @(posedge clk); #1;
    // Reset: everything low, even with requests pending
    ifu_valid = 1; lsu_valid = 1; mem_ready = 1;
    step(); step();
    ifu_valid = 0; lsu_valid = 0; rst = 0;
    step();

    // IFU only, response two cycles after acceptance
    ifu_valid = 1; ifu_addr = 32'h8000_0000; mem_ready = 1;
    #1 check("ifu_only_ready", {63'd0, ifu_ready}, 64'd1);
    step();
    ifu_valid = 0; step();
    mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    #1 check("ifu_only_resp", {ifu_rvalid, ifu_err, lsu_rvalid, ifu_rdata}, {1'b1, 1'b0, 1'b0, 32'h0000_0413});
    step();
    mem_rvalid = 0;

    // Simultaneous requests: LSU store first, IFU after the store ack
    ifu_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0f;
    #1 check("simul_lsu_first", {lsu_ready, ifu_ready, mem_wen, mem_wmask, mem_wdata},
                                {1'b1, 1'b0, 1'b1, 8'h0f, 32'h1234_5678});
    step();
    lsu_valid = 0; mem_rvalid = 1; step();
    mem_rvalid = 0;
    #1 check("simul_ifu_next", {ifu_ready, mem_wen, mem_addr}, {1'b1, 1'b0, 32'h8000_0004});
    step();
    mem_rvalid = 1; step();
    mem_rvalid = 0; ifu_valid = 0; step();

    // Starvation: four LSU grants then IFU
    ifu_valid = 1; lsu_valid = 1; lsu_wen = 0; mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("starve_grant", {62'd0, ifu_ready, lsu_ready}, (i == 4) ? 64'd2 : 64'd1);
      step();
      mem_rvalid = 1; step();
      mem_rvalid = 0;
    end
    #1 check("starve_cleared", {62'd0, ifu_ready, lsu_ready}, 64'd1);
    step();
    ifu_valid = 0; lsu_valid = 0; mem_rvalid = 1; step();
    mem_rvalid = 0; step();

    // Timeout on an LSU load
    lsu_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000; mem_ready = 1;
    step();
    lsu_valid = 0;
    for (int k = 1; k < TMO; k++) step();
    #1 check("timeout_resp", {lsu_rvalid, lsu_err, ifu_rvalid, lsu_rdata}, {1'b1, 1'b1, 1'b0, 32'hdead_beef});
    step();
    #1 check("timeout_idle", {63'd0, busy}, 64'd0);
    step();

    // Reset mid-transaction; late rvalid ignored, new request accepted
    ifu_valid = 1; ifu_addr = 32'h8000_0010; mem_ready = 1;
    step();
    ifu_valid = 0; rst = 1; step();
    rst = 0; mem_rvalid = 1; ifu_valid = 1; ifu_addr = 32'h8000_0020;
    #1 check("rst_mid", {61'd0, ifu_rvalid, busy, ifu_ready}, 64'd1);
    step();
    ifu_valid = 0; step();
    mem_rvalid = 0; step();

    // Backpressure: grant held stable until mem_ready
    ifu_valid = 1; ifu_addr = 32'h8000_0040; mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_hold", {mem_valid, ifu_ready, mem_addr}, {1'b1, 1'b0, 32'h8000_0040});
      step();
    end
    mem_ready = 1;
    #1 check("bp_release", {63'd0, ifu_ready}, 64'd1);
    step();
    ifu_valid = 0; mem_rvalid = 1; step();
    mem_rvalid = 0; step();

    // Random traffic
    ifu_pend = 0; lsu_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (last_ifu_acc) ifu_pend = 0;
      if (last_lsu_acc) lsu_pend = 0;
      if (!ifu_pend && $urandom_range(2) == 0) begin
        ifu_pend = 1; ifu_addr = $urandom;
      end
      if (!lsu_pend && $urandom_range(2) == 0) begin
        lsu_pend = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
        lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
      end
      ifu_valid  = ifu_pend;
      lsu_valid  = lsu_pend;
      mem_ready  = ($urandom_range(9) < 7);
      mem_rvalid = m_busy ? ($urandom_range(9) < 3) : ($urandom_range(19) == 0);
      mem_rdata  = $urandom;
      rst        = ($urandom_range(299) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single PMEM port between instruction fetch (IFU) and load/store (LSU) for the multi-cycle CPU.
- Accepts one request at a time over valid/ready, tracks the single outstanding transaction, and routes the response back to its owner.
- LSU has default priority; a starvation counter periodically forces IFU priority.
- A timeout converts a lost response into an error response.

Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants while IFU is waiting before IFU gets priority (≥1).
- TIMEOUT, 255: cycles to wait for mem_rvalid before an error response (≥1).
- ERR_DATA, 32'hdead_beef: rdata returned on timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- ifu_valid  in  1  IFU request valid.
- ifu_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_rvalid  out  1  IFU response valid (one-cycle pulse).
- ifu_rdata  out  32  fetched instruction.
- ifu_err  out  1  IFU response is a timeout error.
- lsu_valid  in  1  LSU request valid.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  data address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  8  store/load category mask (PMEM wmask encoding).
- lsu_rvalid  out  1  LSU response valid (pulse).
- lsu_rdata  out  32  load data.
- lsu_err  out  1  LSU timeout error.
- mem_valid  out  1  request to PMEM.
- mem_ready  in  1  PMEM accepts request.
- mem_addr  out  32  forwarded address.
- mem_wen  out  1  forwarded write enable (0 for IFU).
- mem_wdata  out  32  forwarded write data (0 for IFU).
- mem_wmask  out  8  forwarded mask (0 for IFU).
- mem_rvalid  in  1  PMEM response valid.
- mem_rdata  in  32  PMEM response data.
- busy  out  1  a transaction is outstanding (state != IDLE).

Behaviour:
- States: IDLE, WAIT_IFU, WAIT_LSU. Registered: state, starve_cnt ($clog2(STARVE_LIMIT+1) bits), tmo_cnt (8+ bits, enough for TIMEOUT).
- Reset: while rst=1 all outputs are 0 at the next edge; state=IDLE, counters=0. Reset mid-transaction abandons it; a late mem_rvalid in IDLE is ignored and never forwarded.

IDLE arbitration (combinational):
- prefer_ifu = (starve_cnt == STARVE_LIMIT).
- Winner:
  - IFU if ifu_valid and (!lsu_valid or prefer_ifu);
  - else LSU if lsu_valid;
  - else none.
- mem_valid = winner exists; mem_* carry the winner's payload.
- winner_ready = mem_ready; the loser's ready = 0.

IDLE transitions:
- On mem_valid & mem_ready → WAIT_<winner>; tmo_cnt=0.

starve_cnt (updated on accepted grants in IDLE only):
- LSU grant while ifu_valid: saturating +1.
- IFU grant: clear to 0.
- Cycle in IDLE with ifu_valid=0: clear to 0.

WAIT_x:
- mem_valid=0; both ready=0; tmo_cnt increments each cycle.
- If mem_rvalid: x_rvalid=1, x_rdata=mem_rdata, x_err=0 in the same cycle (combinational pass-through) → IDLE.
- Else if tmo_cnt == TIMEOUT-1: x_rvalid=1, x_rdata=ERR_DATA, x_err=1 → IDLE. A later stray mem_rvalid is ignored.
- Stores also wait for mem_rvalid (write ack); rdata is don't-care.
- Non-owner rvalid/err always 0; rdata=0 when rvalid=0.

Timing and handshake rules:
- A new request can be granted in the cycle after the response: back-to-back latency is at least 2 cycles per transaction.
- Requesters hold valid and payload stable until ready; the arbiter never retracts a grant while mem_ready=0 unless the priority inputs change.
- Simultaneous ifu_valid & lsu_valid with starve_cnt < STARVE_LIMIT: LSU wins.
- mem_rvalid in the same cycle as the timeout expiry: the real response wins (err=0).
- Outputs depend combinationally on mem_ready/mem_rvalid; no combinational path from mem_* back to ifu/lsu valid.

Test Plan:
- IFU only: ifu_addr=0x8000_0000, mem_ready=1, mem_rvalid two cycles later with rdata=0x0000_0413 → ifu_ready pulses in cycle 0; ifu_rvalid=1, ifu_rdata=0x0000_0413, ifu_err=0; lsu_rvalid stays 0.
- Simultaneous requests, STARVE_LIMIT=4, both valid: LSU store addr=0x8000_1000, wdata=0x1234_5678, wmask=0x0F → LSU granted first; mem_wen=1, mem_wmask=0x0F; IFU granted after the LSU response.
- Starvation: lsu_valid and ifu_valid held high for 5 grants → grants are LSU×4, then IFU; starve_cnt returns to 0.
- Timeout, TIMEOUT=8: LSU load accepted, mem_rvalid never asserted → lsu_rvalid=1, lsu_err=1, lsu_rdata=0xdead_beef exactly 8 cycles after acceptance; busy then 0.
- Reset mid-transaction: IFU accepted, rst=1 for 1 cycle, then mem_rvalid=1 → no ifu_rvalid; busy=0; a new request is accepted the next cycle.
- Backpressure: mem_ready=0 for 3 cycles with ifu_valid=1 → mem_valid=1 with stable mem_addr, ifu_ready=0 until mem_ready=1.
